// File: rtl/ahb_mtx_dec_param.sv
// AHB bus-matrix input-stage decoder with per-port region compare, a data-phase return mux and a built-in ERROR default slave.
// Optional: define DEC_ERR_CAPTURE_EN to add err_addr/err_count capture of unmapped accesses.

module ahb_mtx_dec_region (
   input  logic [21:0] addr,
   input  logic [21:0] base,
   input  logic [21:0] limit,
   input  logic        en,
   output logic        hit
);
   assign hit = en & (addr >= base) & (addr <= limit);
endmodule

module ahb_mtx_dec_param #(
   parameter int                      NUM_PORTS    = 4,
   parameter int                      DATA_W       = 32,
   parameter int                      USER_W       = 32,
   parameter logic [22*NUM_PORTS-1:0] REGION_BASE  = {NUM_PORTS{22'h0}},
   parameter logic [22*NUM_PORTS-1:0] REGION_LIMIT = {NUM_PORTS{22'h0}},
   parameter logic [NUM_PORTS-1:0]    REGION_EN    = {NUM_PORTS{1'b1}}
) (
   input  logic                        HCLK,
   input  logic                        HRESET,
   input  logic                        HREADYS,
   input  logic                        sel_dec,
   input  logic [21:0]                 decode_addr_dec,
   input  logic [1:0]                  trans_dec,
   input  logic [NUM_PORTS-1:0]        active_in,
   input  logic [NUM_PORTS-1:0]        readyout_in,
   input  logic [2*NUM_PORTS-1:0]      resp_in,
   input  logic [DATA_W*NUM_PORTS-1:0] rdata_in,
   input  logic [USER_W*NUM_PORTS-1:0] ruser_in,
   output logic [NUM_PORTS-1:0]        sel_out,
   output logic                        active_dec,
   output logic                        HREADYOUTS,
   output logic [1:0]                  HRESPS,
   output logic [DATA_W-1:0]           HRDATAS,
   output logic [USER_W-1:0]           HRUSERS
`ifdef DEC_ERR_CAPTURE_EN
   ,
   output logic [21:0]                 err_addr,
   output logic [7:0]                  err_count
`endif
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ERR1 = 2'd1;
   localparam logic [1:0] ST_ERR2 = 2'd2;

   logic [NUM_PORTS-1:0] hit;
   logic [PW-1:0]        hit_port, addr_port, dp_port;
   logic                 hit_any, sticky, addr_def, dp_def, def_access;
   logic [1:0]           state, state_nxt;

   genvar g;
   generate
      for (g = 0; g < NUM_PORTS; g++) begin : g_rgn
         ahb_mtx_dec_region u_rgn (
            .addr  (decode_addr_dec),
            .base  (REGION_BASE[22*g +: 22]),
            .limit (REGION_LIMIT[22*g +: 22]),
            .en    (REGION_EN[g]),
            .hit   (hit[g])
         );
      end
   endgenerate

   // Scan downward so the lowest matching index is the last one written.
   always_comb begin
      hit_port = '0;
      hit_any  = 1'b0;
      for (int i = NUM_PORTS-1; i >= 0; i--) begin
         if (hit[i]) begin
            hit_port = PW'(i);
            hit_any  = 1'b1;
         end
      end
   end

   // IDLE transfers stay on the current data port so a locked burst cannot be split.
   assign sticky     = !dp_def && (trans_dec == 2'b00);
   assign addr_port  = sticky ? dp_port : hit_port;
   assign addr_def   = !sticky && !hit_any;
   assign def_access = HREADYS & sel_dec & addr_def & trans_dec[1];

   always_comb begin
      sel_out = '0;
      if (sel_dec && !addr_def)
         sel_out[addr_port] = 1'b1;
   end

   assign active_dec = addr_def ? 1'b1 : active_in[addr_port];

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dp_def  <= 1'b1;
         dp_port <= '0;
         state   <= ST_IDLE;
      end else begin
         if (HREADYS) begin
            dp_def  <= addr_def;
            dp_port <= addr_port;
         end
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = ST_IDLE;
      case (state)
         ST_IDLE: state_nxt = def_access ? ST_ERR1 : ST_IDLE;
         ST_ERR1: state_nxt = ST_ERR2;
         ST_ERR2: state_nxt = def_access ? ST_ERR1 : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      HREADYOUTS = 1'b1;
      HRESPS     = 2'b00;
      HRDATAS    = '0;
      HRUSERS    = '0;
      if (dp_def) begin
         HREADYOUTS = (state != ST_ERR1);
         HRESPS     = (state == ST_IDLE) ? 2'b00 : 2'b01;
      end else begin
         HREADYOUTS = readyout_in[dp_port];
         HRESPS     = resp_in[2*dp_port +: 2];
         HRDATAS    = rdata_in[DATA_W*dp_port +: DATA_W];
         HRUSERS    = ruser_in[USER_W*dp_port +: USER_W];
      end
   end

`ifdef DEC_ERR_CAPTURE_EN
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         err_addr  <= '0;
         err_count <= '0;
      end else if (def_access && (state != ST_ERR1)) begin
         err_addr <= decode_addr_dec;
         if (err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end
`endif

endmodule
